memoria_dados_param: RTL and testbench
======================================

# memoria_dados_param

Parametrised data memory for the uniciclo datapath, successor to the fixed 8-bit data memory. Byte-addressed, little-endian storage with sized accesses (byte/half/word), sign or zero extension on loads, alignment checking, and a configurable wait-state handshake so the datapath can be exercised against slower memory. Sits between the ALU address output and the register-file write-back mux.

## Interface

- DW, 32, data width in bits; legal values 8, 16, 32
- AW, 8, byte-address width; memory holds 2^AW bytes
- LATENCIA, 0, wait cycles inserted before completion; 0..7
- Clock  in  1  single clock, rising-edge active
- Reset  in  1  asynchronous, active-high
- Endereco  in  AW  byte address
- DadoEscr  in  DW  store data, right-justified
- MenWrite  in  1  store request
- MenRead  in  1  load request
- Tamanho  in  2  00 byte, 01 half, 10 word, 11 reserved
- SemSinal  in  1  1 = zero-extend loads, 0 = sign-extend
- DadoLido  out  DW  load result, valid while Pronto=1
- Pronto  out  1  one-cycle completion pulse
- Erro  out  1  access rejected; valid while Pronto=1

## Operation

- States: OCIOSO, ESPERA, CONCLUIDO.
- Accept: in OCIOSO or CONCLUIDO, MenWrite|MenRead high at a rising edge captures Endereco, DadoEscr, Tamanho, SemSinal and the operation. If both are high, the write is taken, the read is dropped.
- After accept: LATENCIA=0 → CONCLUIDO; else ESPERA, with a counter loaded with LATENCIA-1, decremented per edge; at 0 → CONCLUIDO.
- CONCLUIDO lasts one cycle unless a new request is accepted on its exit edge; otherwise → OCIOSO.
- Requests while in ESPERA are ignored, not queued. Inputs may change freely after acceptance.
- Errors: Tamanho=11; Tamanho exceeding DW; half with Endereco[0]≠0; word with Endereco[1:0]≠0. An erroneous access writes nothing, DadoLido=0, Erro=1.
- Store: writes the 1/2/4 lowest bytes of DadoEscr to Endereco.. upward, little-endian. The write commits on the edge entering CONCLUIDO.
- Load: reads the same bytes and extends them to DW per SemSinal. A word load with DW=32 ignores SemSinal.
- A load in the access immediately after a store to the same bytes returns the new data.
- Address arithmetic stays within AW bits; aligned accesses never wrap.

## Timing

- Request accepted at edge k → Pronto, DadoLido, Erro valid in the cycle after edge k+LATENCIA. Throughput is one access per LATENCIA+1 cycles.
- DadoLido holds its last value outside Pronto. A store leaves DadoLido at 0.
- Reset (asynchronous) → OCIOSO, Pronto=0, Erro=0, DadoLido=0, counter=0.
- Memory contents are not cleared by reset. A pending store not yet committed is aborted.
- Reset released mid-cycle: the first acceptable edge is the first rising edge with Reset low.

## Structure

- Package memoria_pkg holds:
  - Tamanho encodings TAM_BYTE, TAM_MEIA, TAM_PALAVRA
  - the state enum estado_t {OCIOSO, ESPERA, CONCLUIDO}
  - the function computing the byte-enable mask from Tamanho and Endereco
- Sub-module banco_bytes: 2^AW×8 array, DW/8 byte-lane write enables, combinational read of DW/8 consecutive bytes.
- The FSM, alignment check and load extension live in the top.

## Test plan

Bench configuration: DW=32, AW=8, LATENCIA=2.

- Word store 0xDEADBEEF @0x10, then word load @0x10 → 0xDEADBEEF, Erro=0; Pronto rises exactly 2 edges after each accept edge.
- Loads after that store:
  - byte @0x13, SemSinal=0 → 0xFFFFFFDE
  - byte @0x13, SemSinal=1 → 0x000000DE
  - half @0x12, SemSinal=0 → 0xFFFFDEAD
- Byte store 0x55 @0x11, then word load @0x10 → 0xDEAD55EF.
- Half store @0x11 → Pronto with Erro=1, DadoLido=0; word load @0x10 still 0xDEAD55EF. Tamanho=11 → Erro=1.
- Word store 0x12345678 @0x20 with Reset pulsed during ESPERA → all outputs 0 immediately; later word load @0x20 returns the prior contents (0x00000000 after a preload of 0).
- Cases that must each be accepted as exactly one access, with Pronto pulsed once per access:
  - MenWrite=MenRead=1 with 0xAAAAAAAA @0x30 → stored, DadoLido=0
  - a new request held during ESPERA → ignored
  - back-to-back request on the CONCLUIDO edge → accepted

Source files
------------

// File: rtl/memoria_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memoria_pkg
// Description : Shared definitions for the parametrised data memory:
//               access-size encodings, the access state enum and the
//               byte-enable mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memoria_pkg;

   // Tamanho encodings; 2'b11 is reserved and always rejected
   localparam logic [1:0] TAM_BYTE    = 2'b00;
   localparam logic [1:0] TAM_MEIA    = 2'b01;
   localparam logic [1:0] TAM_PALAVRA = 2'b10;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      ESPERA    = 2'd1,
      CONCLUIDO = 2'd2
   } estado_t;

   // Lane mask relative to the access address (lane 0 = byte at Endereco).
   // A misaligned or reserved access yields an empty mask, which the top
   // uses directly as its alignment/encoding error indication.
   function automatic logic [3:0] mascara_bytes(input logic [1:0] tam,
                                                input logic [1:0] end_lo);
      logic [3:0] m;
      m = 4'b0000;
      case (tam)
         TAM_BYTE:    m = 4'b0001;
         TAM_MEIA:    if (!end_lo[0])       m = 4'b0011;
         TAM_PALAVRA: if (end_lo == 2'b00)  m = 4'b1111;
         default:     m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/banco_bytes.sv
`default_nettype none
// ============================================================================
// Module      : banco_bytes
// Description : 2^AW x 8 byte array with DW/8 byte-lane write enables and a
//               combinational read of DW/8 consecutive bytes (little-endian).
//               Contents are never cleared.
// Ports       : clk        - write clock (rising edge)
//               i_endereco - base byte address of the lanes
//               i_we       - per-lane write enable (lane i -> i_endereco+i)
//               i_dado     - write data, lane i in bits [8i+7:8i]
//               o_dado     - read data, lane i from byte i_endereco+i
// Revision    : 1.0 - initial release
// ============================================================================
module banco_bytes #(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic            clk,
   input  logic [AW-1:0]   i_endereco,
   input  logic [DW/8-1:0] i_we,
   input  logic [DW-1:0]   i_dado,
   output logic [DW-1:0]   o_dado
);

   localparam int c_NB = DW / 8;

   logic [7:0] r_mem [0:(2**AW)-1];

   // Lane addresses are computed in AW bits, so they wrap inside the array
   always_ff @(posedge clk) begin
      for (int i = 0; i < c_NB; i++) begin
         if (i_we[i]) begin
            r_mem[i_endereco + AW'(i)] <= i_dado[8*i +: 8];
         end
      end
   end

   generate
      for (genvar g = 0; g < c_NB; g++) begin : g_leitura
         assign o_dado[8*g +: 8] = r_mem[i_endereco + AW'(g)];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/memoria_dados_param.sv
`default_nettype none
// ============================================================================
// Module      : memoria_dados_param
// Description : Parametrised byte-addressed data memory with byte/half/word
//               accesses, sign/zero extension on loads, alignment checking
//               and a programmable number of wait states.
// Ports       : Clock    - rising-edge clock
//               Reset    - asynchronous, active-high
//               Endereco - byte address
//               DadoEscr - store data, right-justified
//               MenWrite - store request (wins over MenRead)
//               MenRead  - load request
//               Tamanho  - 00 byte, 01 half, 10 word, 11 reserved
//               SemSinal - 1 zero-extend, 0 sign-extend loads
//               DadoLido - load result, held between accesses
//               Pronto   - one-cycle completion pulse
//               Erro     - access rejected, valid with Pronto
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_dados_param
   import memoria_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 8,
   parameter int LATENCIA = 0
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [AW-1:0] Endereco,
   input  logic [DW-1:0] DadoEscr,
   input  logic          MenWrite,
   input  logic          MenRead,
   input  logic [1:0]    Tamanho,
   input  logic          SemSinal,
   output logic [DW-1:0] DadoLido,
   output logic          Pronto,
   output logic          Erro
);

   localparam int         c_NB         = DW / 8;
   localparam bit         c_SEM_ESPERA = (LATENCIA == 0);
   localparam logic [2:0] c_CONT_INI   = c_SEM_ESPERA ? 3'd0 : 3'(LATENCIA - 1);

   estado_t       r_estado;
   estado_t       w_prox;
   logic [2:0]    r_cont;

   // Captured request
   logic [AW-1:0] r_end;
   logic [DW-1:0] r_dado_escr;
   logic [1:0]    r_tam;
   logic          r_semsinal;
   logic          r_escrita;

   logic [DW-1:0] r_dado_lido;
   logic          r_erro;

   logic          w_aceita;
   logic          w_conclui;
   logic [AW-1:0] w_end;
   logic [DW-1:0] w_dado_escr;
   logic [1:0]    w_tam;
   logic          w_semsinal;
   logic          w_escrita;
   logic [3:0]    w_mascara;
   logic          w_excede;
   logic          w_erro;
   logic [c_NB-1:0] w_we;
   logic [DW-1:0] w_leitura;
   logic [31:0]   w_bruto;
   logic [31:0]   w_ext;
   logic          w_sinal;
   logic [DW-1:0] w_resultado;

   assign w_aceita  = ((r_estado == OCIOSO) || (r_estado == CONCLUIDO)) &&
                      (MenWrite || MenRead);

   // The edge entering CONCLUIDO both commits a store and latches the result
   assign w_conclui = (w_aceita && c_SEM_ESPERA) ||
                      ((r_estado == ESPERA) && (r_cont == 3'd0));

   // With no wait states the access completes on its own accept edge, so the
   // live inputs must be used; otherwise the captured copy is used.
   assign w_end       = w_aceita ? Endereco : r_end;
   assign w_dado_escr = w_aceita ? DadoEscr : r_dado_escr;
   assign w_tam       = w_aceita ? Tamanho  : r_tam;
   assign w_semsinal  = w_aceita ? SemSinal : r_semsinal;
   assign w_escrita   = w_aceita ? MenWrite : r_escrita;

   assign w_mascara = mascara_bytes(w_tam, w_end[1:0]);
   assign w_excede  = ((w_tam == TAM_MEIA) && (DW < 16)) ||
                      ((w_tam == TAM_PALAVRA) && (DW < 32));
   assign w_erro    = (w_mascara == 4'b0000) || w_excede;

   assign w_we = (w_conclui && w_escrita && !w_erro) ? w_mascara[c_NB-1:0] : '0;

   banco_bytes #(
      .DW (DW),
      .AW (AW)
   ) u_banco (
      .clk        (Clock),
      .i_endereco (w_end),
      .i_we       (w_we),
      .i_dado     (w_dado_escr),
      .o_dado     (w_leitura)
   );

   // Load extension, computed at 32 bits and trimmed to DW
   assign w_bruto = 32'(w_leitura);
   assign w_sinal = !w_semsinal;

   always_comb begin
      w_ext = w_bruto;
      case (w_tam)
         TAM_BYTE: w_ext = {{24{w_sinal & w_bruto[7]}}, w_bruto[7:0]};
         TAM_MEIA: w_ext = {{16{w_sinal & w_bruto[15]}}, w_bruto[15:0]};
         default:  w_ext = w_bruto;
      endcase
   end

   assign w_resultado = (w_escrita || w_erro) ? '0 : w_ext[DW-1:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_estado    <= OCIOSO;
         r_cont      <= 3'd0;
         r_end       <= '0;
         r_dado_escr <= '0;
         r_tam       <= 2'b00;
         r_semsinal  <= 1'b0;
         r_escrita   <= 1'b0;
         r_dado_lido <= '0;
         r_erro      <= 1'b0;
      end else begin
         r_estado <= w_prox;
         if (w_aceita) begin
            r_end       <= Endereco;
            r_dado_escr <= DadoEscr;
            r_tam       <= Tamanho;
            r_semsinal  <= SemSinal;
            r_escrita   <= MenWrite;
            r_cont      <= c_CONT_INI;
         end else if ((r_estado == ESPERA) && (r_cont != 3'd0)) begin
            r_cont <= r_cont - 3'd1;
         end
         if (w_conclui) begin
            r_dado_lido <= w_resultado;
            r_erro      <= w_erro;
         end
      end
   end

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         OCIOSO, CONCLUIDO: begin
            if (w_aceita) begin
               w_prox = c_SEM_ESPERA ? CONCLUIDO : ESPERA;
            end else begin
               w_prox = OCIOSO;
            end
         end
         ESPERA: begin
            if (r_cont == 3'd0) begin
               w_prox = CONCLUIDO;
            end
         end
         default: w_prox = OCIOSO;
      endcase
   end

   assign Pronto   = (r_estado == CONCLUIDO);
   assign Erro     = r_erro;
   assign DadoLido = r_dado_lido;

endmodule
`default_nettype wire

// File: tb/tb_memoria_dados_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_memoria_dados_param
// Description : Randomised self-checking bench for memoria_dados_param with a
//               byte-array reference model and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_dados_param;

   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int LAT = 2;

   logic          Clock    = 1'b0;
   logic          Reset    = 1'b1;
   logic [AW-1:0] Endereco = '0;
   logic [DW-1:0] DadoEscr = '0;
   logic          MenWrite = 1'b0;
   logic          MenRead  = 1'b0;
   logic [1:0]    Tamanho  = 2'b00;
   logic          SemSinal = 1'b0;
   logic [DW-1:0] DadoLido;
   logic          Pronto;
   logic          Erro;

   memoria_dados_param #(
      .DW       (DW),
      .AW       (AW),
      .LATENCIA (LAT)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Endereco (Endereco),
      .DadoEscr (DadoEscr),
      .MenWrite (MenWrite),
      .MenRead  (MenRead),
      .Tamanho  (Tamanho),
      .SemSinal (SemSinal),
      .DadoLido (DadoLido),
      .Pronto   (Pronto),
      .Erro     (Erro)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] dado;
      logic        erro;
      int          ciclo;
   } esp_t;

   esp_t       q[$];
   logic [7:0] mem_ref [0:255];
   int         n_chk = 0;
   int         n_ok  = 0;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_chk++;
      if (atual === esperado) n_ok++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nome, atual, esperado, cyc);
   endtask

   function automatic logic erro_ref(input logic [1:0] tam, input logic [7:0] a);
      return (tam == 2'd3) || (tam == 2'd1 && a[0]) || (tam == 2'd2 && a[1:0] != 2'd0);
   endfunction

   // Issue one request at the current falling edge; returns at the falling
   // edge where the response is visible, so a following call is back-to-back.
   task automatic emite(input bit we, input bit re, input logic [1:0] tam,
                        input logic [7:0] a, input logic [31:0] d, input bit ss,
                        input bit ruido);
      esp_t        e;
      int          n;
      logic [31:0] v;
      Endereco = a; DadoEscr = d; Tamanho = tam; SemSinal = ss;
      MenWrite = we; MenRead = re;
      e.erro  = erro_ref(tam, a);
      e.ciclo = cyc + 1 + LAT;
      e.dado  = 32'd0;
      n = 1 << tam;
      if (!e.erro) begin
         if (we) begin
            for (int i = 0; i < n; i++) mem_ref[a + i] = d[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_ref[a + i]) << (8 * i));
            if (!ss && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            e.dado = v;
         end
      end
      q.push_back(e);
      @(negedge Clock);
      // Inputs are scrambled after acceptance; the access must not notice
      Endereco = 8'($urandom); DadoEscr = $urandom;
      Tamanho = 2'($urandom); SemSinal = 1'($urandom);
      MenWrite = 1'b0;
      MenRead  = ruido;
      repeat (LAT) @(negedge Clock);
      MenWrite = 1'b0;
      MenRead  = 1'b0;
   endtask

   // Monitor: every Pronto must match the queue head in cycle and content
   always @(negedge Clock) begin
      esp_t e;
      if (!Reset) begin
         if (q.size() > 0 && q[0].ciclo <= cyc) begin
            e = q.pop_front();
            chk("pronto_timing", {31'd0, Pronto}, 32'd1);
            chk("dado_lido", DadoLido, e.dado);
            chk("erro", {31'd0, Erro}, {31'd0, e.erro});
         end else if (Pronto) begin
            chk("pronto_extra", {31'd0, Pronto}, 32'd0);
         end
      end
   end

   initial begin
      logic [1:0] tam;
      logic [7:0] a;
      bit         we, re;

      for (int i = 0; i < 256; i++) mem_ref[i] = 8'h00;

      repeat (2) @(negedge Clock);
      chk("reset_pronto", {31'd0, Pronto}, 32'd0);
      chk("reset_erro", {31'd0, Erro}, 32'd0);
      chk("reset_dado", DadoLido, 32'd0);
      #2 Reset = 1'b0;
      @(negedge Clock);

      // Preload whole memory with zeros
      for (int i = 0; i < 256; i += 4) emite(1, 0, 2'd2, 8'(i), 32'd0, 0, 0);

      emite(1, 0, 2'd2, 8'h10, 32'hDEADBEEF, 0, 0);
      emite(0, 1, 2'd2, 8'h10, 32'd0, 0, 0);
      emite(0, 1, 2'd0, 8'h13, 32'd0, 0, 0);
      emite(0, 1, 2'd0, 8'h13, 32'd0, 1, 0);
      emite(0, 1, 2'd1, 8'h12, 32'd0, 0, 0);
      emite(1, 0, 2'd0, 8'h11, 32'h00000055, 0, 0);
      emite(0, 1, 2'd2, 8'h10, 32'd0, 0, 0);
      emite(1, 0, 2'd1, 8'h11, 32'h00001234, 0, 0);
      emite(0, 1, 2'd2, 8'h10, 32'd0, 0, 0);
      emite(0, 1, 2'd3, 8'h10, 32'd0, 0, 0);
      emite(1, 1, 2'd2, 8'h30, 32'hAAAAAAAA, 0, 0);
      emite(0, 1, 2'd2, 8'h30, 32'd0, 1, 1);
      emite(0, 1, 2'd2, 8'h10, 32'd0, 0, 0);

      // Store aborted by reset while waiting
      @(negedge Clock);
      Endereco = 8'h20; DadoEscr = 32'h12345678; Tamanho = 2'd2; MenWrite = 1'b1;
      @(negedge Clock);
      MenWrite = 1'b0;
      #1 Reset = 1'b1;
      #1;
      chk("rst_async_pronto", {31'd0, Pronto}, 32'd0);
      chk("rst_async_erro", {31'd0, Erro}, 32'd0);
      chk("rst_async_dado", DadoLido, 32'd0);
      #1 Reset = 1'b0;
      repeat (4) @(negedge Clock);
      emite(0, 1, 2'd2, 8'h20, 32'd0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge Clock);
         we  = 1'($urandom);
         re  = we ? 1'($urandom) : 1'b1;
         tam = 2'($urandom_range(0, 3));
         a   = 8'($urandom);
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         emite(we, re, tam, a, $urandom, 1'($urandom), $urandom_range(0, 4) == 0);
      end

      for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge Clock);
      if (q.size() > 0) chk("timeout_pendentes", q.size(), 32'd0);
      @(negedge Clock);
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
